// File: rtl/seq_mul_param.sv
// Iterative shift-add multiplier producing the full 2*W-bit product, one multiplier bit per clock.
// Optional macro SEQ_MUL_EARLY_EXIT_EN ends the iteration once the remaining multiplier bits are zero.
module seq_mul_param #(
    parameter int W = 64
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           a_signed,
    input  logic           b_signed,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] y
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [2*W-1:0] r_y;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_count;
    logic           r_neg;
    logic           r_done;

    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_last;

    // Negating -2^(W-1) in W bits yields 2^(W-1) as an unsigned magnitude.
    always_comb begin
        w_a_neg = a_signed & a[W-1];
        w_b_neg = b_signed & b[W-1];
        w_mag_a = w_a_neg ? -a : a;
        w_mag_b = w_b_neg ? -b : b;
    end

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // The step taken on this edge consumes mplier[0]; nothing is left once the upper bits are clear.
    assign w_last = (r_count == CW'(W - 1)) || (r_mplier[W-1:1] == '0);
`else
    assign w_last = (r_count == CW'(W - 1));
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN:    if (w_last) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_y      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{W{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_count  <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                    end
                end
                S_RUN: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                end
                S_FINISH: begin
                    r_y <= r_neg ? -r_acc : r_acc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = r_done;
        y    = r_y;
    end

endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench for seq_mul_param: a W=8 instance for directed/random cases and a W=64 instance for a random sweep.
// Expected latency follows SEQ_MUL_EARLY_EXIT_EN when the bench is built with that macro.
`timescale 1ns/1ps
module tb_seq_mul_param;
    localparam int W0 = 8;
    localparam int W1 = 64;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    logic        st0 = 1'b0, as0 = 1'b0, bs0 = 1'b0, busy0, done0;
    logic [7:0]  a0 = '0, b0 = '0;
    logic [15:0] y0;
    logic        st1 = 1'b0, as1 = 1'b0, bs1 = 1'b0, busy1, done1;
    logic [63:0] a1 = '0, b1 = '0;
    logic [127:0] y1;

    seq_mul_param #(.W(W0)) u_dut8 (
        .Clk(Clk), .Rst(Rst), .start(st0), .a(a0), .b(b0),
        .a_signed(as0), .b_signed(bs0), .busy(busy0), .done(done0), .y(y0)
    );

    seq_mul_param #(.W(W1)) u_dut64 (
        .Clk(Clk), .Rst(Rst), .start(st1), .a(a1), .b(b1),
        .a_signed(as1), .b_signed(bs1), .busy(busy1), .done(done1), .y(y1)
    );

    typedef struct {
        int           dut;
        logic [127:0] y;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           next_free[2];
    logic [127:0] y_hold[2];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp_v);
        end
    endtask

    // Operand value as a mathematical integer, interpreting the low w bits per signedness.
    function automatic logic signed [129:0] sval(input int w, input logic [63:0] v, input bit sg);
        logic signed [129:0] r;
        logic [63:0]         m;
        m = (w == 64) ? v : (v & ((64'd1 << w) - 64'd1));
        r = $signed({66'd0, m});
        if (sg && m[w-1]) r = r - (130'sd1 <<< w);
        return r;
    endfunction

    task automatic drive(input int d, input bit st, input logic [63:0] a, input logic [63:0] b,
                         input bit as, input bit bs);
        int                  w, e, lat;
        logic signed [129:0] sa, sbv, p, mb;
        exp_t                x;
        w   = (d != 0) ? W1 : W0;
        st0 = 1'b0;
        st1 = 1'b0;
        if (d == 0) begin
            st0 = st; a0 = a[7:0]; b0 = b[7:0]; as0 = as; bs0 = bs;
        end else begin
            st1 = st; a1 = a; b1 = b; as1 = as; bs1 = bs;
        end
        e = cyc + 1;
        if (st && e >= next_free[d]) begin
            sa  = sval(w, a, as);
            sbv = sval(w, b, bs);
            p   = sa * sbv;
            mb  = (sbv < 0) ? -sbv : sbv;
            lat = w + 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
            lat = 2;
            for (int i = 0; i < w; i++) if (mb[i]) lat = i + 2;
`endif
            x.dut = d;
            x.y   = (d != 0) ? p[127:0] : {112'd0, p[15:0]};
            x.acc = e;
            x.lat = lat;
            sb.push_back(x);
            next_free[d] = e + lat + 1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        st0 = 1'b0;
        st1 = 1'b0;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_busy8", 128'(busy0), 128'd0);
        check("rst_done8", 128'(done0), 128'd0);
        check("rst_y8",    128'(y0),    128'd0);
        check("rst_busy64", 128'(busy1), 128'd0);
        check("rst_done64", 128'(done1), 128'd0);
        check("rst_y64",    y1,          128'd0);
        sb.delete();
        next_free[0] = 0; next_free[1] = 0;
        y_hold[0] = '0;   y_hold[1] = '0;
        Rst = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout cyc=%0d actual=%0d pending required=0", cyc, sb.size());
            sb.delete();
        end
    endtask

    task automatic mon(input int d, input logic bz, input logic dn, input logic [127:0] yv);
        bit ours;
        ours = (sb.size() > 0) && (sb[0].dut == d) && (cyc >= sb[0].acc);
        if (ours && cyc < sb[0].acc + sb[0].lat) begin
            check("busy_run",   128'(bz), 128'd1);
            check("done_early", 128'(dn), 128'd0);
            check("y_hold",     yv,       y_hold[d]);
        end else if (ours) begin
            check("done_latency", 128'(dn), 128'd1);
            check("busy_at_done", 128'(bz), 128'd0);
            check("y_result",     yv,       sb[0].y);
            y_hold[d] = sb[0].y;
            void'(sb.pop_front());
        end else begin
            check("no_done",   128'(dn), 128'd0);
            check("busy_idle", 128'(bz), 128'd0);
            check("y_hold",    yv,       y_hold[d]);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            mon(0, busy0, done0, {112'd0, y0});
            mon(1, busy1, done1, y1);
        end
    end

    logic [7:0]  dir_a [7] = '{8'h03, 8'hFD, 8'hFF, 8'h80, 8'h80, 8'h5A, 8'h11};
    logic [7:0]  dir_b [7] = '{8'h05, 8'h05, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h04};
    bit          dir_as[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit          dir_bs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] dir_y [7] = '{16'h000F, 16'hFFF1, 16'hFE01, 16'h4000, 16'h8080, 16'h0000, 16'h0044};

    initial begin
        do_reset();
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b1, 64'(dir_a[i]), 64'(dir_b[i]), dir_as[i], dir_bs[i]);
            wait_drain();
            check("dir_y", 128'(y0), 128'(dir_y[i]));
        end

        // Start pulses while the first op is in flight must be ignored.
        drive(0, 1'b1, 64'd3, 64'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 64'h77, 64'h99, 1'b1, 1'b1);
        wait_drain();
        check("ignored_start_y", 128'(y0), 128'h000F);

        for (int i = 0; i < 3 * (W0 + 2) + 2; i++) drive(0, 1'b1, 64'hC3, 64'h5A, 1'b1, 1'b0);
        wait_drain();

        drive(0, 1'b1, 64'h12, 64'h34, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < W0 + 6; i++) drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            drive(0, ($urandom % 3) == 0, 64'($urandom), 64'($urandom),
                  1'($urandom), 1'($urandom));
        wait_drain();

        for (int i = 0; i < 2500; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = (($urandom % 4) == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
            if (($urandom % 8) == 0) rb = {1'b1, 63'd0};
            drive(1, ($urandom % 2) == 0, ra, rb, 1'($urandom), 1'($urandom));
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
